// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tristate_bus_arbiter: round-robin owner of a shared tri bus, z turnaround |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tristate_bus_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N           = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1,
  localparam int IDXW       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data,
  output logic [N-1:0]         grant,
  output logic [IDXW-1:0]      owner,
  output logic                 busy,
  output tri   [WIDTH-1:0]     y
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [HW-1:0]   c_max_hold    = HW'(MAX_HOLD);
  localparam logic [TW-1:0]   c_turn_cycles = TW'(TURN_CYCLES);
  localparam logic [N-1:0]    c_one         = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t            r_state;
  logic [N-1:0]      r_grant;
  logic [IDXW-1:0]   r_owner;
  logic [HW-1:0]     r_hold;
  logic [TW-1:0]     r_turn;

  logic [IDXW-1:0]   w_winner;
  logic              w_any;
  logic              w_others;
  logic              w_release;

  // Search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    logic              v_found;
    logic [IDXW-1:0]   v_idx;
    w_winner = r_owner;
    v_found  = 1'b0;
    v_idx    = '0;
    for (int i = 1; i <= N; i++) begin
      v_idx = IDXW'((int'(r_owner) + i) % N);
      if (!v_found && req[v_idx]) begin
        v_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign w_any     = |req;
  assign w_others  = |(req & ~r_grant);
  assign w_release = !req[r_owner] || ((r_hold == c_max_hold) && w_others);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= IDXW'(N - 1);
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_OWN;
            r_grant <= c_one << w_winner;
            r_owner <= w_winner;
            r_hold  <= HW'(1);
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_state <= S_TURN;
            r_grant <= '0;
            r_turn  <= TW'(1);
          end else if (r_hold != c_max_hold) begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_TURN: begin
          if (r_turn == c_turn_cycles) begin
            r_turn <= '0;
            if (w_any) begin
              r_state <= S_OWN;
              r_grant <= c_one << w_winner;
              r_owner <= w_winner;
              r_hold  <= HW'(1);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = |r_grant;

  // Driven straight from the registered grant so reset floats the bus at once.
  assign y = (|r_grant) ? data[int'(r_owner)*WIDTH +: WIDTH] : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tristate_bus_arbiter: two arbiters (turnaround 1 and 3) vs a model     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tristate_bus_arbiter;

  localparam int WIDTH    = 8;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDXW     = $clog2(N);

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]       grant0, grant1;
  logic [IDXW-1:0]    owner0, owner1;
  logic               busy0, busy1;
  tri   [WIDTH-1:0]   y0, y1;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .data(data),
    .grant(grant0), .owner(owner0), .busy(busy0), .y(y0)
  );

  tristate_bus_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .data(data),
    .grant(grant1), .owner(owner1), .busy(busy1), .y(y1)
  );

  // Reference model: who owns the bus, for how long, and how many z cycles remain.
  int tc [2] = '{1, 3};
  bit m_has   [2];
  int m_owner [2];
  int m_run   [2];
  int m_gap   [2];
  int waitc   [2][N];

  int n_vec = 0;
  int n_err = 0;

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return last;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_has[d] = 0; m_owner[d] = N - 1; m_run[d] = 0; m_gap[d] = 0;
      for (int k = 0; k < N; k++) waitc[d][k] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    for (int d = 0; d < 2; d++) begin
      if (m_has[d]) begin
        bit others;
        others = (r & ~(N'(1) << m_owner[d])) != 0;
        if (!r[m_owner[d]] || (m_run[d] >= MAX_HOLD && others)) begin
          m_has[d] = 0;
          m_gap[d] = tc[d];
        end else if (m_run[d] < MAX_HOLD) begin
          m_run[d]++;
        end
      end else if (m_gap[d] > 1) begin
        m_gap[d]--;
      end else begin
        m_gap[d] = 0;
        if (r != 0) begin
          m_owner[d] = rr_pick(m_owner[d], r);
          m_has[d]   = 1;
          m_run[d]   = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0]     g, eg;
      logic [IDXW-1:0]  o;
      logic             b;
      logic [WIDTH-1:0] yy, ey;
      int               bound;
      g  = (d == 0) ? grant0 : grant1;
      o  = (d == 0) ? owner0 : owner1;
      b  = (d == 0) ? busy0  : busy1;
      yy = (d == 0) ? y0     : y1;
      eg = m_has[d] ? (N'(1) << m_owner[d]) : '0;
      ey = m_has[d] ? data[m_owner[d]*WIDTH +: WIDTH] : {WIDTH{1'bz}};
      chk($sformatf("grant%0d", d), 32'(g), 32'(eg));
      chk($sformatf("owner%0d", d), 32'(o), 32'(m_owner[d]));
      chk($sformatf("busy%0d", d),  32'(b), 32'(m_has[d]));
      chk($sformatf("y%0d", d),     {24'b0, yy}, {24'b0, ey});
      bound = (N - 1) * (MAX_HOLD + tc[d]) + tc[d];
      for (int k = 0; k < N; k++) begin
        if (reset_n && req[k] && !g[k]) waitc[d][k]++;
        else waitc[d][k] = 0;
        if (waitc[d][k] > 0)
          chk($sformatf("fair%0d_req%0d", d, k), 32'(waitc[d][k] <= bound), 32'd1);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    for (int k = 0; k < N; k++) data[k*WIDTH +: WIDTH] = WIDTH'($urandom());
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [N-1:0] cur;
    reset_n = 1'b0;
    req     = '1;
    data    = '0;
    model_reset();
    @(negedge clk);

    // Reset held with all requests high, then first grant to requester 0.
    repeat (3) step(4'b1111);
    reset_n = 1'b1;
    repeat (2) step(4'b1111);
    repeat (4) step(4'b0000);

    // Lone requester 2 for three cycles, release, back to idle.
    repeat (3) step(4'b0100);
    repeat (4) step(4'b0000);

    // Everyone requesting: rotate with pre-emption after MAX_HOLD.
    repeat (45) step(4'b1111);
    repeat (6) step(4'b0000);

    // Sole requester never pre-empted.
    repeat (20) step(4'b0010);
    repeat (6) step(4'b0000);

    // Owner 0 releases with req[3] pending; req[1] pulses during turnaround.
    repeat (3) step(4'b0001);
    step(4'b1000);
    step(4'b1010);
    repeat (4) step(4'b1000);
    step(4'b1010);
    repeat (3) step(4'b1010);
    repeat (6) step(4'b0000);

    // Asynchronous reset between edges while owning.
    repeat (3) step(4'b0001);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    step(4'b0000);
    reset_n = 1'b1;
    repeat (4) step(4'b0000);

    // Randomized request patterns, held for random stretches.
    cur = '0;
    repeat (900) begin
      if ($urandom_range(0, 3) == 0)
        cur = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom());
      step(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
